// File: rtl/rc5_req_scheduler_if.sv
// Requester, response and RC5 core signals shared by the scheduler and its environment.
// slave = scheduler side, master = requesters plus core side.
interface rc5_req_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_op;
    logic [5*NUM_REQ-1:0]   req_rounds;
    logic [32*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [127:0]           key;

    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [31:0]            rsp_data;
    logic                   rsp_err;
    logic                   busy;

    logic                   core_rst;
    logic                   core_encrypt;
    logic                   core_decrypt;
    logic [4:0]             core_num_rounds;
    logic [127:0]           core_key;
    logic [31:0]            core_d_in;
    logic [31:0]            core_d_out;
    logic                   core_done;

    modport slave (
        input  req_valid, req_op, req_rounds, req_data, key, rsp_ready,
        input  core_d_out, core_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy,
        output core_rst, core_encrypt, core_decrypt, core_num_rounds, core_key, core_d_in
    );

    modport master (
        output req_valid, req_op, req_rounds, req_data, key, rsp_ready,
        output core_d_out, core_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  core_rst, core_encrypt, core_decrypt, core_num_rounds, core_key, core_d_in
    );
endinterface

// File: rtl/rc5_req_scheduler.sv
// Round-robin sharing of one RC5-16 core; accept T, strobe T+1, rsp_valid T+rounds+3 (T+1 if rejected).
// One job in flight: requests wait in IDLE, the response is held in RESP until its rsp_ready.
module rc5_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = 24
) (
    input  logic               clk,
    input  logic               rst,
    rc5_req_scheduler_if.slave bus
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               op_q, op_d;
    logic [4:0]         rounds_q, rounds_d;
    logic [31:0]        data_q, data_d;
    logic [127:0]       key_q, key_d;
    logic [31:0]        result_q, result_d;
    logic               err_q, err_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               flush_q, flush_d;

    logic               gnt_vld;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     cand;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] rsp_oh;
    logic               sel_op;
    logic [4:0]         sel_rounds;
    logic [31:0]        sel_data;

    // Walk from the highest offset down so the closest requester to rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh     = '0;
        rsp_oh     = '0;
        sel_op     = 1'b0;
        sel_rounds = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_oh[i]  = gnt_vld;
                sel_op     = bus.req_op[i];
                sel_rounds = bus.req_rounds[5*i +: 5];
                sel_data   = bus.req_data[32*i +: 32];
            end
            if (id_q == IDW'(i)) begin
                rsp_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        rounds_d = rounds_q;
        data_d   = data_q;
        key_d    = key_q;
        result_d = result_q;
        err_d    = err_q;
        wd_d     = wd_q;
        flush_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d     = gnt_idx;
                    op_d     = sel_op;
                    rounds_d = sel_rounds;
                    data_d   = sel_data;
                    key_d    = bus.key;
                    if (sel_rounds > 5'd16) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (bus.core_done) begin
                    result_d = bus.core_d_out;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    // Hung core: pulse its reset for one cycle and report the abort.
                    result_d = '0;
                    err_d    = 1'b1;
                    flush_d  = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= 1'b0;
            rounds_q <= '0;
            data_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            rounds_q <= rounds_d;
            data_q   <= data_d;
            key_q    <= key_d;
            result_q <= result_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.req_ready       = (state_q == IDLE) ? gnt_oh : '0;
    assign bus.rsp_valid       = (state_q == RESP) ? rsp_oh : '0;
    assign bus.rsp_data        = result_q;
    assign bus.rsp_err         = err_q;
    assign bus.busy            = (state_q != IDLE);

    // The core reads num_rounds every round, so its inputs come straight from the latches.
    assign bus.core_rst        = rst & ~flush_q;
    assign bus.core_encrypt    = (state_q == ISSUE) & ~op_q;
    assign bus.core_decrypt    = (state_q == ISSUE) & op_q;
    assign bus.core_num_rounds = rounds_q;
    assign bus.core_key        = key_q;
    assign bus.core_d_in       = data_q;
endmodule

// File: doc/rc5_req_scheduler.md
Name: rc5_req_scheduler

Overview:
Shares the single RC5-16 core (32-bit block, 128-bit key, 0–16 rounds, one-cycle done pulse) between NUM_REQ requesters. Arbitration is round-robin. The block latches one job, issues a one-cycle encrypt/decrypt strobe, holds the core inputs stable, captures the result on done, and returns it through a per-requester valid/ready response. A watchdog recovers a hung core; jobs with illegal round counts are rejected.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, $clog2(NUM_REQ), requester index width
TIMEOUT, 24, WAIT-state cycles without core_done before the job is aborted (must be > 18)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester job request
req_op  in  NUM_REQ  per-requester op: 0 = encrypt, 1 = decrypt
req_rounds  in  5*NUM_REQ  per-requester round count, slice i = [5i+4:5i]
req_data  in  32*NUM_REQ  per-requester input block
req_ready  out  NUM_REQ  one-hot accept pulse
key  in  128  shared key, sampled at accept
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_data  out  32  result block
rsp_err  out  1  1 = rejected (rounds>16) or timed out
busy  out  1  high whenever state != IDLE
core_rst  out  1  core reset, active-low
core_encrypt  out  1  core encrypt strobe
core_decrypt  out  1  core decrypt strobe
core_num_rounds  out  5  latched round count
core_key  out  128  latched key
core_d_in  out  32  latched block
core_d_out  in  32  core result, valid only while core_done = 1
core_done  in  1  core completion pulse

Behaviour:
- Reset (rst = 0 at a clock edge): state = IDLE, rr_ptr = 0, and all latches (op, rounds, data, key, id, result, err, watchdog count) = 0.
  - All outputs are 0 except core_rst.
  - core_rst = rst & ~flush, so the core is held in reset together with this block.
  - A reset mid-job drops the job and any pending response silently.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - In the same cycle: req_ready[g] = 1 (combinational), and latch op, rounds, data, key and id = g.
  - If the latched rounds > 16: result = 0, err = 1, next state RESP. The core is never strobed.
  - Otherwise next state ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - For exactly one cycle, core_encrypt = ~op and core_decrypt = op.
  - Watchdog count cleared; next state WAIT.
- WAIT:
  - Strobes are 0. Watchdog counts up by 1 per cycle.
  - On core_done = 1: capture core_d_out, err = 0, next state RESP.
  - Else, on count == TIMEOUT-1: result = 0, err = 1, flush = 1 for exactly the next cycle (core_rst low one cycle), next state RESP.
  - core_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[id] = 1; rsp_data and rsp_err hold their captured values.
  - Remain in RESP until rsp_ready[id] = 1. On that cycle: next state IDLE, rr_ptr = (id+1) mod NUM_REQ.
  - rsp_ready on other bits is ignored.
- core_num_rounds, core_key and core_d_in are driven from the latches and stay stable from ISSUE through RESP, because the core reads num_rounds every round.
- Latency: accept at cycle T, strobe at T+1, core_done at T+rounds+2, rsp_valid first high at T+rounds+3.
  - rounds = 0 gives rsp_valid at T+3.
  - Rejected job gives rsp_valid at T+1.
- Throughput: one job in flight. The next accept occurs no earlier than the cycle after the rsp handshake.
- req_* inputs are ignored outside IDLE. A requester keeps req_valid high until it sees req_ready.
- A core_done arriving outside WAIT is ignored.

Test Plan:
- Single encrypt: req 0, rounds = 12, data 0x12345678, key all-zero, core model with done at issue+13. Expect req_ready[0] at T; core_encrypt only at T+1; rsp_valid[0] at T+15 carrying the model's output with rsp_err = 0; core_num_rounds = 12 held throughout.
- Round-robin: all 4 requesters valid continuously, rsp_ready tied high. Expect grant order 0,1,2,3,0. Then with only req 2 valid, expect back-to-back grants of 2.
- Loopback with the real core: encrypt 0xDEADBEEF (rounds 16), then decrypt the result (rounds 16). Expect rsp_data = 0xDEADBEEF. Repeat with rounds = 0 and rounds = 1.
- Illegal rounds: req 1, rounds = 17. Expect no core strobe, rsp_valid[1] at T+1 with rsp_data = 0 and rsp_err = 1.
- Watchdog: core model never asserts done. Expect core_rst low for exactly 1 cycle after 24 WAIT cycles, then rsp_err = 1 and rsp_data = 0. The next job completes normally.
- Backpressure and reset: hold rsp_ready[0] = 0 for 10 cycles. rsp_valid[0] and rsp_data stay stable and no new grant occurs. Asserting rst = 0 mid-WAIT returns everything to the reset state with rr_ptr = 0.
